reg_dump: RTL and testbench
===========================

# reg_dump

Debug readout engine for the pipelined RiSC-16 core. It is the reader counterpart of the register file's write port: it borrows one asynchronous read port of the register file and walks an inclusive, wrap-capable range of register indices. Each word is streamed out, tagged with its index, over a valid/ready interface to a debug host or trace buffer. It runs alongside the core; core writes are never blocked.

## Interface
- p_WORD_LEN, 16, data word width
- p_REG_ADDR_LEN, 3, register index width
- p_REG_FILE_SIZE, 8, number of registers; must be ≤ 2^p_REG_ADDR_LEN

Ports:
- i_clk  in  1  clock; all state updates on posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  request a dump; sampled only in IDLE
- i_first  in  p_REG_ADDR_LEN  first index, sampled with i_start
- i_last  in  p_REG_ADDR_LEN  last index (inclusive), sampled with i_start
- i_abort  in  1  cancel the dump in progress
- o_rd_addr  out  p_REG_ADDR_LEN  register-file read address
- i_rd_data  in  p_WORD_LEN  register-file read data, combinational from o_rd_addr
- o_dump_valid  out  1  output word valid
- i_dump_ready  in  1  sink accepts the word
- o_dump_data  out  p_WORD_LEN  register value
- o_dump_addr  out  p_REG_ADDR_LEN  index of o_dump_data
- o_dump_last  out  1  final word of the dump
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: o_rd_addr=0. On i_start=1 with i_abort=0:
  - latch the current address cur=i_first and end=i_last;
  - go to READ.
- READ: o_rd_addr=cur. At the clock edge:
  - capture i_rd_data into o_dump_data and cur into o_dump_addr;
  - set o_dump_last=(cur==end);
  - go to HOLD.
- HOLD: o_dump_valid=1. Data, address and last stay stable until handshake (o_dump_valid & i_dump_ready).
  - On handshake with o_dump_last=1: go to DONE.
  - On handshake otherwise: cur = (cur==p_REG_FILE_SIZE-1) ? 0 : cur+1; go to READ.
- DONE: o_done=1 for one cycle, then IDLE.
- Range handling:
  - word count = ((end − first) mod p_REG_FILE_SIZE) + 1;
  - first==end produces one word;
  - end<first wraps through index p_REG_FILE_SIZE−1 to 0.
- Index 0 returns whatever the register file supplies; the register file guarantees 0. The block does no special casing.
- Indices ≥ p_REG_FILE_SIZE on i_first/i_last are reduced modulo p_REG_FILE_SIZE when latched.
- i_abort in READ, HOLD or DONE: next state is IDLE. o_dump_valid drops the next cycle and o_done is not pulsed. A word presented in the abort cycle that also handshakes counts as delivered.
- i_abort in IDLE: no effect, and it blocks an i_start in the same cycle.
- i_start while busy: ignored, no queuing.

## Timing
- Reset (asynchronous, immediate): state=IDLE, and every output (o_rd_addr, o_dump_data, o_dump_addr, o_dump_valid, o_dump_last, o_busy, o_done) is 0.
- Reset mid-dump aborts silently. No o_done.
- Cycle 0: i_start sampled. Cycle 1: READ. Cycle 2: first o_dump_valid.
- With i_dump_ready held high, one word every 2 cycles. An N-word dump shows o_done at cycle 2N+1.
- o_busy is high from cycle 1 through the DONE cycle inclusive.
- Snapshot semantics: each word is the register value at the READ-cycle edge.
  - A core write on that same edge is not seen, because the register file updates on posedge and the read is sampled before it.
  - A write in an earlier cycle is seen.
- Outputs in HOLD must not change while i_dump_ready=0, even if the register file is written.

## Test plan
- Full dump: preload r1..r7 = 0x1111..0x7777, first=0, last=7, ready=1.
  - Expect 8 words, (0,0x0000)…(7,0x7777).
  - o_dump_last on index 7 only; o_done at cycle 17.
- Backpressure: same dump with i_dump_ready low for 3 cycles on each word.
  - Data, address and last stay stable while stalled; no loss or duplication; order preserved.
- Wrap and single: first=6, last=1 gives indices 6,7,0,1 with last on 1. first=last=3 gives one word, last=1, o_done at cycle 3.
- Concurrent write:
  - core writes r4=0xBEEF on the READ edge for index 4: dumped value is the old value;
  - write one cycle earlier: dumped value is 0xBEEF.
- Abort and start:
  - i_abort on the 2nd HOLD: IDLE next cycle, no o_done;
  - i_start during busy is ignored;
  - i_start+i_abort in IDLE does not start.
- Reset mid-dump: assert i_rst_n=0 in HOLD. All outputs drop to 0 without waiting for a clock edge. After release, a new i_start works normally.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the pipelined RiSC-16 core.
// Borrows one asynchronous read port of the register file and walks an
// inclusive, wrap-capable index range. Each word is streamed to a debug host
// over valid/ready, tagged with its register index.
module reg_dump #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [p_REG_ADDR_LEN-1:0] i_first,
  input  logic [p_REG_ADDR_LEN-1:0] i_last,
  input  logic                      i_abort,
  output logic [p_REG_ADDR_LEN-1:0] o_rd_addr,
  input  logic [p_WORD_LEN-1:0]     i_rd_data,
  output logic                      o_dump_valid,
  input  logic                      i_dump_ready,
  output logic [p_WORD_LEN-1:0]     o_dump_data,
  output logic [p_REG_ADDR_LEN-1:0] o_dump_addr,
  output logic                      o_dump_last,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned              SIZE_U  = p_REG_FILE_SIZE;
  localparam logic [p_REG_ADDR_LEN-1:0] TOP_IDX = p_REG_ADDR_LEN'(p_REG_FILE_SIZE - 1);

  // Indices outside the register file fold back into range when latched.
  function automatic logic [p_REG_ADDR_LEN-1:0] wrap_idx(input logic [p_REG_ADDR_LEN-1:0] idx);
    int unsigned v;
    v = 32'(idx);
    v = v % SIZE_U;
    return v[p_REG_ADDR_LEN-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [p_REG_ADDR_LEN-1:0] cur_q, cur_d;
  logic [p_REG_ADDR_LEN-1:0] last_idx_q, last_idx_d;
  logic [p_WORD_LEN-1:0]     dump_data_q, dump_data_d;
  logic [p_REG_ADDR_LEN-1:0] dump_addr_q, dump_addr_d;
  logic                      dump_last_q, dump_last_d;
  logic                      dump_valid_q, dump_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [p_REG_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic                      handshake;

  assign handshake = dump_valid_q & i_dump_ready;

  // Next-state logic: walk the range one word at a time, READ then HOLD,
  // and derive every output from the next state so they come out of flops.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_idx_d  = last_idx_q;
    dump_data_d = dump_data_q;
    dump_addr_d = dump_addr_q;
    dump_last_d = dump_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          cur_d      = wrap_idx(i_first);
          last_idx_d = wrap_idx(i_last);
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          dump_data_d = i_rd_data;
          dump_addr_d = cur_q;
          dump_last_d = (cur_q == last_idx_q);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (handshake && !dump_last_q) begin
          cur_d = (cur_q == TOP_IDX) ? '0 : cur_q + 1'b1;
        end
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          state_d = dump_last_q ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dump_valid_d = (state_d == S_HOLD);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    rd_addr_d    = (state_d == S_READ) ? cur_d : '0;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_idx_q   <= '0;
      dump_data_q  <= '0;
      dump_addr_q  <= '0;
      dump_last_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_idx_q   <= last_idx_d;
      dump_data_q  <= dump_data_d;
      dump_addr_q  <= dump_addr_d;
      dump_last_q  <= dump_last_d;
      dump_valid_q <= dump_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign o_rd_addr    = rd_addr_q;
  assign o_dump_valid = dump_valid_q;
  assign o_dump_data  = dump_data_q;
  assign o_dump_addr  = dump_addr_q;
  assign o_dump_last  = dump_last_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: scoreboard bench for reg_dump with a small register file model.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_first = 3'd0;
  logic [2:0]  i_last = 3'd0;
  logic        i_abort = 1'b0;
  logic [2:0]  o_rd_addr;
  logic [15:0] i_rd_data;
  logic        o_dump_valid;
  logic        i_dump_ready = 1'b1;
  logic [15:0] o_dump_data;
  logic [2:0]  o_dump_addr;
  logic        o_dump_last;
  logic        o_busy;
  logic        o_done;

  // register file model: written on posedge, read combinationally, r0 reads 0
  logic [15:0] rf [8];
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;
  int done_rel = -1;
  logic stall_mode = 1'b0;
  int stall_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [15:0] held_data = '0;
  logic [2:0]  held_addr = '0;
  logic        held_last = 1'b0;

  reg_dump #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_first     (i_first),
    .i_last      (i_last),
    .i_abort     (i_abort),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_dump_valid(o_dump_valid),
    .i_dump_ready(i_dump_ready),
    .o_dump_data (o_dump_data),
    .o_dump_addr (o_dump_addr),
    .o_dump_last (o_dump_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // cycle counter used to time o_done relative to the start cycle
  always @(posedge clk) cyc++;

  // register file write port
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  assign i_rd_data = (o_rd_addr == 3'd0) ? 16'h0000 : rf[o_rd_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [15:0] d, input logic l);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // sink ready: always high, or low for 3 cycles at the start of each word
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      i_dump_ready = 1'b1;
      stall_cnt = 0;
    end else if (o_dump_valid) begin
      if (stall_cnt < 3) begin
        i_dump_ready = 1'b0;
        stall_cnt++;
      end else begin
        i_dump_ready = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  // monitor: pops the scoreboard on every handshake, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (o_done) begin
        done_count++;
        done_rel = cyc - start_cyc;
      end
      if (prev_stall && o_dump_valid) begin
        check_output("hold_stable", 32'({o_dump_last, o_dump_addr, o_dump_data}),
                     32'({held_last, held_addr, held_data}));
      end
      if (o_dump_valid && i_dump_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word actual addr=%0d data=0x%0h expected none",
                   o_dump_addr, o_dump_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("word", 32'({o_dump_last, o_dump_addr, o_dump_data}),
                       32'({e.last, e.addr, e.data}));
        end
      end
      prev_stall = o_dump_valid && !i_dump_ready;
      held_data  = o_dump_data;
      held_addr  = o_dump_addr;
      held_last  = o_dump_last;
    end
  end

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // issue a dump request; returns at the start of cycle 1
  task automatic apply_stimulus(input logic [2:0] f, input logic [2:0] l);
    @(posedge clk); #1;
    i_start = 1'b1; i_first = f; i_last = l;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // wait (bounded) for the o_done pulse, then check its timing and the queue
  task automatic wait_done(input int base, input int exp_rel, input string name);
    for (int i = 0; i < 300 && done_count == base; i++) begin
      @(posedge clk); #2;
    end
    check_output({name, "_done_count"}, 32'(done_count), 32'(base + 1));
    check_output({name, "_done_cycle"}, 32'(done_rel), 32'(exp_rel));
    check_output({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
    check_output({name, "_data"}, 32'(o_dump_data), 32'd0);
    check_output({name, "_addr"}, 32'(o_dump_addr), 32'd0);
    check_output({name, "_valid"}, 32'(o_dump_valid), 32'd0);
    check_output({name, "_last"}, 32'(o_dump_last), 32'd0);
    check_output({name, "_busy"}, 32'(o_busy), 32'd0);
    check_output({name, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int base;
    logic [15:0] val;

    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // preload r0..r7
    write_reg(3'd0, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      val = 16'h1111 * 16'(i);
      write_reg(3'(i), val);
    end

    $display("[TB] full dump 0..7");
    for (int i = 0; i < 8; i++) push_exp(3'(i), 16'h1111 * 16'(i), (i == 7));
    base = done_count;
    apply_stimulus(3'd0, 3'd7);
    wait_done(base, 17, "full");

    $display("[TB] backpressure dump 0..7");
    stall_mode = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(3'(i), 16'h1111 * 16'(i), (i == 7));
    base = done_count;
    apply_stimulus(3'd0, 3'd7);
    wait_done(base, 41, "stall");
    stall_mode = 1'b0;

    $display("[TB] wrap dump 6..1");
    push_exp(3'd6, 16'h6666, 1'b0);
    push_exp(3'd7, 16'h7777, 1'b0);
    push_exp(3'd0, 16'h0000, 1'b0);
    push_exp(3'd1, 16'h1111, 1'b1);
    base = done_count;
    apply_stimulus(3'd6, 3'd1);
    wait_done(base, 9, "wrap");

    $display("[TB] single dump 3..3");
    push_exp(3'd3, 16'h3333, 1'b1);
    base = done_count;
    apply_stimulus(3'd3, 3'd3);
    wait_done(base, 3, "single");

    $display("[TB] write on the READ edge is not seen");
    push_exp(3'd4, 16'h4444, 1'b1);
    base = done_count;
    @(posedge clk); #1;
    i_start = 1'b1; i_first = 3'd4; i_last = 3'd4;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_done(base, 3, "wr_same");

    $display("[TB] write one cycle earlier is seen");
    write_reg(3'd4, 16'h4444);
    push_exp(3'd4, 16'hBEEF, 1'b1);
    base = done_count;
    @(posedge clk); #1;
    i_start = 1'b1; i_first = 3'd4; i_last = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    wr_en = 1'b0;
    wait_done(base, 3, "wr_early");

    $display("[TB] abort on second HOLD");
    push_exp(3'd0, 16'h0000, 1'b0);
    push_exp(3'd1, 16'h1111, 1'b0);
    base = done_count;
    apply_stimulus(3'd0, 3'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check_output("abort_busy", 32'(o_busy), 32'd0);
    check_output("abort_valid", 32'(o_dump_valid), 32'd0);
    repeat (6) @(posedge clk);
    #2;
    check_output("abort_no_done", 32'(done_count), 32'(base));
    check_output("abort_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] start while busy is ignored");
    push_exp(3'd2, 16'h2222, 1'b0);
    push_exp(3'd3, 16'h3333, 1'b1);
    base = done_count;
    apply_stimulus(3'd2, 3'd3);
    @(posedge clk); #1;
    i_start = 1'b1; i_first = 3'd5; i_last = 3'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(base, 5, "busy_start");
    repeat (6) @(posedge clk);
    #2;
    check_output("busy_start_idle", 32'(o_busy), 32'd0);
    check_output("busy_start_no_extra", 32'(done_count), 32'(base + 1));

    $display("[TB] start with abort in IDLE");
    base = done_count;
    @(posedge clk); #1;
    i_start = 1'b1; i_abort = 1'b1; i_first = 3'd1; i_last = 3'd2;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    check_output("idle_abort_busy", 32'(o_busy), 32'd0);
    repeat (5) @(posedge clk);
    #2;
    check_output("idle_abort_no_done", 32'(done_count), 32'(base));

    $display("[TB] reset during HOLD");
    stall_mode = 1'b1;
    base = done_count;
    apply_stimulus(3'd0, 3'd7);
    @(posedge clk); #1;
    check_output("pre_reset_valid", 32'(o_dump_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    stall_mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_output("reset_no_done", 32'(done_count), 32'(base));

    $display("[TB] dump after reset 5..6");
    push_exp(3'd5, 16'h5555, 1'b0);
    push_exp(3'd6, 16'h6666, 1'b1);
    base = done_count;
    apply_stimulus(3'd5, 3'd6);
    wait_done(base, 5, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
